// File: rtl/lfsr_prng_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared constants for the LFSR family: structure selectors,
//               maximal-length default taps/seeds for common widths, and a
//               helper that turns a Fibonacci tap mask into the equivalent
//               Galois XOR mask.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    // Fibonacci tap masks (bit i set = q[i] feeds the XOR), all maximal length.
    localparam logic [3:0]  c_TAPS_W4  = 4'b1100;
    localparam logic [7:0]  c_TAPS_W8  = 8'hB8;
    localparam logic [15:0] c_TAPS_W16 = 16'hB400;
    localparam logic [31:0] c_TAPS_W32 = 32'h8020_0003;

    // Seeds: MSB only; any nonzero value would do.
    localparam logic [3:0]  c_SEED_W4  = 4'b1000;
    localparam logic [7:0]  c_SEED_W8  = 8'h80;
    localparam logic [15:0] c_SEED_W16 = 16'h8000;
    localparam logic [31:0] c_SEED_W32 = 32'h8000_0000;

    // Galois mask = {TAPS[WIDTH-2:0], 1'b1}, zero above WIDTH-1.
    function automatic logic [31:0] galois_mask(input logic [31:0] taps,
                                                input int          width);
        logic [31:0] m;
        m = {taps[30:0], 1'b1};
        if (width < 32)
            m = m & ((32'd1 << width) - 32'd1);
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_prng_next_state.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_next_state
// Description : Purely combinational LFSR successor function, Fibonacci or
//               Galois selected by MODE. Reused by scrambler blocks.
// Ports       : i_state    - current state (WIDTH)
//               o_next     - successor state (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_next_state
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter int               MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    generate
        if (MODE == MODE_GAL) begin : g_galois
            localparam logic [WIDTH-1:0] c_GAL_MASK =
                WIDTH'(galois_mask(32'(TAPS), WIDTH));
            // Shift left; when the bit falling out of the MSB is 1, fold in the mask.
            assign o_next = {i_state[WIDTH-2:0], 1'b0}
                          ^ (i_state[WIDTH-1] ? c_GAL_MASK : '0);
        end else begin : g_fibonacci
            logic w_fb;
            assign w_fb   = ^(i_state & TAPS);
            assign o_next = {i_state[WIDTH-2:0], w_fb};
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/lfsr_prng.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_prng
// Description : Parametrised LFSR pseudo-random generator with enable,
//               runtime seed load, period-wrap pulse and optional all-zero
//               lock-up recovery (macro LFSR_LOCKUP_RECOVERY_EN).
// Ports       : clock       - rising-edge clock
//               reset_n     - synchronous active-low reset
//               enable      - advance one state per cycle
//               load        - load seed_in (beats enable)
//               seed_in     - runtime seed (WIDTH)
//               q           - registered state (WIDTH)
//               bit_out     - serial output, q[WIDTH-1]
//               period_wrap - pulse when a step lands back on the seed
//               lockup      - pulse on all-zero recovery (0 if macro unset)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_prng
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100,
    parameter logic [WIDTH-1:0] SEED  = 4'b1000,
    parameter int               MODE  = MODE_FIB
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] q,
    output logic             bit_out,
    output logic             period_wrap,
    output logic             lockup
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_seed;
    logic             r_wrap;
    logic [WIDTH-1:0] w_next;

    lfsr_next_state #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_next_state (
        .i_state (r_q),
        .o_next  (w_next)
    );

`ifdef LFSR_LOCKUP_RECOVERY_EN
    logic r_lock;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_q    <= SEED;
            r_seed <= SEED;
            r_wrap <= 1'b0;
            r_lock <= 1'b0;
        end else if (load) begin
            // A zero seed would freeze the generator; substitute SEED.
            if (seed_in == '0) begin
                r_q    <= SEED;
                r_seed <= SEED;
                r_lock <= 1'b1;
            end else begin
                r_q    <= seed_in;
                r_seed <= seed_in;
                r_lock <= 1'b0;
            end
            r_wrap <= 1'b0;
        end else if (enable) begin
            if (r_q == '0) begin
                r_q    <= SEED;
                r_wrap <= 1'b0;
                r_lock <= 1'b1;
            end else begin
                r_q    <= w_next;
                r_wrap <= (w_next == r_seed);
                r_lock <= 1'b0;
            end
        end else begin
            r_wrap <= 1'b0;
            r_lock <= 1'b0;
        end
    end

    assign lockup = r_lock;
`else
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_q    <= SEED;
            r_seed <= SEED;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_q    <= seed_in;
            r_seed <= seed_in;
            r_wrap <= 1'b0;
        end else if (enable) begin
            r_q    <= w_next;
            r_wrap <= (w_next == r_seed);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign lockup = 1'b0;
`endif

    assign q           = r_q;
    assign bit_out     = r_q[WIDTH-1];
    assign period_wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prng.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_prng
// Description : Directed self-checking bench for lfsr_prng. One Fibonacci
//               and one Galois instance share the same stimulus; expected
//               sequences are hand-computed constants for the 4-bit defaults.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_prng;

    logic       clock;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic [3:0] seed_in;
    logic [3:0] q_fib, q_gal;
    logic       bit_fib, bit_gal;
    logic       wrap_fib, wrap_gal;
    logic       lock_fib, lock_gal;

    int n_cmp = 0;
    int n_bad = 0;

    // Full 15-step sequences from seed 1000.
    logic [3:0] c_FIB_SEQ [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                                   4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                                   4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    logic [3:0] c_GAL_SEQ [15] = '{4'b1001, 4'b1011, 4'b1111, 4'b0111, 4'b1110,
                                   4'b0101, 4'b1010, 4'b1101, 4'b0011, 4'b0110,
                                   4'b1100, 4'b0001, 4'b0010, 4'b0100, 4'b1000};

    lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b1000), .MODE(0)) u_dut_fib (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .seed_in     (seed_in),
        .q           (q_fib),
        .bit_out     (bit_fib),
        .period_wrap (wrap_fib),
        .lockup      (lock_fib)
    );

    lfsr_prng #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b1000), .MODE(1)) u_dut_gal (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .load        (load),
        .seed_in     (seed_in),
        .q           (q_gal),
        .bit_out     (bit_gal),
        .period_wrap (wrap_gal),
        .lockup      (lock_gal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle so registered outputs are stable.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, " fib wrap"}, 32'(wrap_fib), 0);
        check({tag, " gal wrap"}, 32'(wrap_gal), 0);
        check({tag, " fib lock"}, 32'(lock_fib), 0);
        check({tag, " gal lock"}, 32'(lock_gal), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        enable  = 1'b0;
        load    = 1'b0;
        seed_in = 4'b0000;
        tick();
        tick();

        // Reset state
        check("rst fib q", 32'(q_fib), 32'b1000);
        check("rst gal q", 32'(q_gal), 32'b1000);
        check("rst fib bit", 32'(bit_fib), 1);
        check("rst gal bit", 32'(bit_gal), 1);
        check_quiet("rst");

        // Full period from reset seed
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            check($sformatf("step%0d fib q", i + 1), 32'(q_fib), 32'(c_FIB_SEQ[i]));
            check($sformatf("step%0d gal q", i + 1), 32'(q_gal), 32'(c_GAL_SEQ[i]));
            check($sformatf("step%0d fib wrap", i + 1), 32'(wrap_fib), (i == 14) ? 1 : 0);
            check($sformatf("step%0d gal wrap", i + 1), 32'(wrap_gal), (i == 14) ? 1 : 0);
        end

        // Load beats enable, no step that cycle
        load    = 1'b1;
        seed_in = 4'b0110;
        tick();
        check("load fib q", 32'(q_fib), 32'b0110);
        check("load gal q", 32'(q_gal), 32'b0110);
        check_quiet("load");
        load = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (i == 0) begin
                check("ld step1 fib q", 32'(q_fib), 32'b1101);
                check("ld step1 gal q", 32'(q_gal), 32'b1100);
            end
            check($sformatf("ld step%0d fib wrap", i + 1), 32'(wrap_fib), (i == 14) ? 1 : 0);
            check($sformatf("ld step%0d gal wrap", i + 1), 32'(wrap_gal), (i == 14) ? 1 : 0);
        end
        check("ld period fib q", 32'(q_fib), 32'b0110);
        check("ld period gal q", 32'(q_gal), 32'b0110);

        // Hold: enable 1,0,0,1 from 0110
        enable = 1'b1;
        tick();
        check("hold0 fib q", 32'(q_fib), 32'b1101);
        check("hold0 gal q", 32'(q_gal), 32'b1100);
        enable = 1'b0;
        tick();
        check("hold1 fib q", 32'(q_fib), 32'b1101);
        check("hold1 gal q", 32'(q_gal), 32'b1100);
        check_quiet("hold1");
        tick();
        check("hold2 fib q", 32'(q_fib), 32'b1101);
        check("hold2 gal q", 32'(q_gal), 32'b1100);
        check_quiet("hold2");
        enable = 1'b1;
        tick();
        check("hold3 fib q", 32'(q_fib), 32'b1010);
        check("hold3 gal q", 32'(q_gal), 32'b0001);

        // All-zero seed load
        enable  = 1'b0;
        load    = 1'b1;
        seed_in = 4'b0000;
        tick();
        load   = 1'b0;
`ifdef LFSR_LOCKUP_RECOVERY_EN
        check("zero fib q", 32'(q_fib), 32'b1000);
        check("zero gal q", 32'(q_gal), 32'b1000);
        check("zero fib lock", 32'(lock_fib), 1);
        check("zero gal lock", 32'(lock_gal), 1);
        enable = 1'b1;
        tick();
        check("zero+1 fib q", 32'(q_fib), 32'b0001);
        check("zero+1 gal q", 32'(q_gal), 32'b1001);
        check("zero+1 fib lock", 32'(lock_fib), 0);
        check("zero+1 gal lock", 32'(lock_gal), 0);
`else
        check("zero fib q", 32'(q_fib), 32'b0000);
        check("zero gal q", 32'(q_gal), 32'b0000);
        check("zero fib lock", 32'(lock_fib), 0);
        check("zero gal lock", 32'(lock_gal), 0);
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("zero en fib q", 32'(q_fib), 32'b0000);
            check("zero en gal q", 32'(q_gal), 32'b0000);
            check("zero en fib lock", 32'(lock_fib), 0);
            check("zero en gal lock", 32'(lock_gal), 0);
        end
`endif

        // Back-to-back loads: last wins
        load    = 1'b1;
        seed_in = 4'b0011;
        tick();
        seed_in = 4'b0101;
        tick();
        check("b2b fib q", 32'(q_fib), 32'b0101);
        check("b2b gal q", 32'(q_gal), 32'b0101);
        load = 1'b0;
        tick();
        check("b2b step fib q", 32'(q_fib), 32'b1011);
        check("b2b step gal q", 32'(q_gal), 32'b1010);

        // Reset mid-sequence beats load and enable
        reset_n = 1'b0;
        load    = 1'b1;
        seed_in = 4'b0110;
        tick();
        check("midrst fib q", 32'(q_fib), 32'b1000);
        check("midrst gal q", 32'(q_gal), 32'b1000);
        check_quiet("midrst");
        reset_n = 1'b1;
        load    = 1'b0;
        tick();
        check("midrst+1 fib q", 32'(q_fib), 32'b0001);
        check("midrst+1 gal q", 32'(q_gal), 32'b1001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_prng.md
# lfsr_prng

- Parametrised pseudo-random generator; successor to the team's fixed 4-bit shift-register generator.
- Configurable width, feedback taps, seed, and Fibonacci or Galois structure.
- Adds enable, runtime seed load, period-wrap detection and all-zero lock-up handling.
- Sits beside test-pattern and scrambler logic; consumers read the parallel state `q` or the serial bit `bit_out`.

## Interface
Parameters:
- `WIDTH`, 4: state width, 3..32.
- `TAPS`, 4'b1100: Fibonacci tap mask; bit i set puts q[i] in the feedback XOR. `TAPS[WIDTH-1]` must be 1.
- `SEED`, 4'b1000: reset value and lock-up recovery value; must be nonzero.
- `MODE`, 0: 0 = Fibonacci, 1 = Galois.

Ports:
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset.
- `enable` in 1: advance one state per cycle while high.
- `load` in 1: load `seed_in` this cycle.
- `seed_in` in WIDTH: runtime seed.
- `q` out WIDTH: registered generator state.
- `bit_out` out 1: `q[WIDTH-1]`.
- `period_wrap` out 1: registered one-cycle pulse.
- `lockup` out 1: registered one-cycle pulse.

## Operation
- **Priority per edge:** reset_n low > load > enable > hold.
- **Reset:** `q`=SEED, seed register=SEED, `period_wrap`=0, `lockup`=0.
- **Fibonacci step:** fb = XOR of q[i] for every TAPS[i]=1; next = {q[WIDTH-2:0], fb}.
- **Galois step:** mask = {TAPS[WIDTH-2:0], 1'b1}; next = {q[WIDTH-2:0], 1'b0} ^ (q[WIDTH-1] ? mask : 0).
- **Default period:** 15 in both modes.
- **Load:** `q`←`seed_in`; seed register←`seed_in`; no step that cycle, even if `enable` is high; `period_wrap` is not asserted.
- **period_wrap:** high the cycle after a step whose next state equals the seed register.
- **enable low:** `q` holds; `period_wrap` and `lockup` are 0.
- **All-zero state:** the only non-advancing state; its handling is set by the macro under Configuration.

## Timing
- Latency is one cycle from the edge sampling enable/load to the new `q`; all outputs come from flops.
- Pulses are single cycle and re-evaluated every edge; never stretched.
- Reset mid-sequence: the next `q` is SEED regardless of load or enable.
- load and enable high together: the load wins, and stepping resumes from the new seed on the next enabled cycle.
- Back-to-back loads: the last one wins.

## Configuration
- **`LFSR_LOCKUP_RECOVERY_EN` defined:**
  - A load with seed_in=0 stores SEED in both `q` and the seed register, and pulses `lockup`.
  - An enabled step from q=0 sets `q`=SEED and pulses `lockup`.
- **Not defined:**
  - Zero loads as-is, and `q` stays 0 while enabled.
  - `lockup` is tied 0.

## Structure
- **Package `lfsr_pkg`:** `MODE_FIB`/`MODE_GAL` constants, default TAPS/SEED localparams for WIDTH 4, 8, 16, 32, and a function computing the Galois mask from TAPS.
- **Sub-module `lfsr_next_state`:** purely combinational (WIDTH, TAPS, MODE → next state), shared with scrambler blocks.
- **Top-level block:** holds the state register, seed register, priority logic and pulse flops.

## Test plan
All cases use defaults unless stated.
- **Reset then Fibonacci stepping:** reset, enable=1 → q = 1000, 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010; `period_wrap` high exactly on the 15th step, as q returns to 1000.
- **Galois stepping:** MODE=1, reset, enable=1 → q = 1001, 1011, 1111, 0111, 1110, 0101, 1010; period 15.
- **Load priority:** load=1 with seed_in=0110 and enable=1 → q=0110 next cycle with no step; `period_wrap` pulses 15 enabled cycles later, when q returns to 0110.
- **Hold:** toggle enable 1,0,0,1 → q advances only on the enabled cycles; pulses stay 0 while disabled.
- **Lock-up with macro:** load seed_in=0000 → q=1000 and `lockup`=1 for one cycle.
- **Lock-up without macro:** same stimulus → q=0000 persists while enabled; `lockup`=0.
- **Reset mid-sequence:** assert reset_n=0 with load=1 → q=1000; pulses 0.
